// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the lsu port arbiter: FSM states, RISC-V
// funct3 size codes and the latched request record.
package lsu_arb_pkg;

   localparam int LSU_ADDR_W = 12;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      READ,
      RESP
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic                  we;
      logic [2:0]            funct3;
      logic [LSU_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
   } req_t;

endpackage

// File: rtl/lsu_arbiter_if.sv
// Request/response bundle for one requester of the lsu port arbiter.
interface lsu_arbiter_if #(
   parameter int ADDR_W = 12
) ();
   logic              req;
   logic              we;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              gnt;
   logic              rsp_valid;
   logic              rsp_err;
   logic [31:0]       rdata;

   modport master (
      output req, we, funct3, addr, wdata,
      input  gnt, rsp_valid, rsp_err, rdata
   );

   modport slave (
      input  req, we, funct3, addr, wdata,
      output gnt, rsp_valid, rsp_err, rdata
   );
endinterface

// File: rtl/lsu_req_decode.sv
// Combinational funct3/address decode: lsu size strobes, alignment/legality
// error, and sign extension of load data (the lsu only zero-extends).
module lsu_req_decode
   import lsu_arb_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] ld_data_i,
   output logic        ld_byte_o,
   output logic        ld_halfword_o,
   output logic        err_o,
   output logic [31:0] ext_data_o
);

   logic misaligned;
   logic illegal;

   // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3_i)
         F3_B, F3_BU: misaligned = 1'b0;
         F3_H, F3_HU: misaligned = addr_lo_i[0];
         F3_W:        misaligned = |addr_lo_i;
         default:     illegal    = 1'b1;
      endcase
      if (we_i && funct3_i[2]) begin
         illegal = 1'b1;
      end
   end

   assign err_o         = misaligned | illegal;
   assign ld_byte_o     = (funct3_i[1:0] == 2'b00);
   assign ld_halfword_o = (funct3_i[1:0] == 2'b01);

   always_comb begin
      case (funct3_i)
         F3_B:    ext_data_o = {{24{ld_data_i[7]}}, ld_data_i[7:0]};
         F3_H:    ext_data_o = {{16{ld_data_i[15]}}, ld_data_i[15:0]};
         default: ext_data_o = ld_data_i;
      endcase
   end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter and access sequencer sharing the single lsu port
// between the core load/store path (m0) and the debug/loader port (m1).
module lsu_arbiter
   import lsu_arb_pkg::*;
#(
   parameter bit RR_EN  = 1'b1,
   parameter int ADDR_W = LSU_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   lsu_arbiter_if.slave      m0_if,
   lsu_arbiter_if.slave      m1_if,
   output logic              lsu_st_en_o,
   output logic              lsu_ld_byte_o,
   output logic              lsu_ld_halfword_o,
   output logic [ADDR_W-1:0] lsu_addr_o,
   output logic [31:0]       lsu_st_data_o,
   input  logic [31:0]       lsu_ld_data_i
);

   state_e           state_q, state_d;
   req_t             req_q, req_d, sel_req;
   logic             winner_q, winner_d;
   logic             last_q, last_d;
   logic [1:0][31:0] rdata_q, rdata_d;

   logic        any_req;
   logic        win_sel;
   logic        dec_ld_byte;
   logic        dec_ld_halfword;
   logic        dec_err;
   logic [31:0] dec_ext_data;
   logic        drive_lsu;

   lsu_req_decode u_decode (
      .we_i          (req_q.we),
      .funct3_i      (req_q.funct3),
      .addr_lo_i     (req_q.addr[1:0]),
      .ld_data_i     (lsu_ld_data_i),
      .ld_byte_o     (dec_ld_byte),
      .ld_halfword_o (dec_ld_halfword),
      .err_o         (dec_err),
      .ext_data_o    (dec_ext_data)
   );

   assign any_req = m0_if.req | m1_if.req;

   // On a tie the round-robin pick is the requester not granted last.
   assign win_sel = RR_EN ? (m1_if.req & (~m0_if.req | ~last_q))
                          : (m1_if.req & ~m0_if.req);

   always_comb begin
      if (win_sel) begin
         sel_req.we     = m1_if.we;
         sel_req.funct3 = m1_if.funct3;
         sel_req.addr   = m1_if.addr;
         sel_req.wdata  = m1_if.wdata;
      end else begin
         sel_req.we     = m0_if.we;
         sel_req.funct3 = m0_if.funct3;
         sel_req.addr   = m0_if.addr;
         sel_req.wdata  = m0_if.wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         req_q    <= '0;
         winner_q <= 1'b0;
         last_q   <= 1'b1;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         winner_q <= winner_d;
         last_q   <= last_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = (dec_err || req_q.we) ? RESP : READ;
         READ:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d    = req_q;
      winner_d = winner_q;
      last_d   = last_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               req_d    = sel_req;
               winner_d = win_sel;
            end
         end
         ACCESS: begin
            if (dec_err || req_q.we) rdata_d[winner_q] = '0;
         end
         READ:    rdata_d[winner_q] = dec_ext_data;
         RESP:    last_d = winner_q;
         default: ;
      endcase
   end

   // Faulting requests never reach the lsu; the address stays up through READ.
   assign drive_lsu = ((state_q == ACCESS) || (state_q == READ)) && !dec_err;

   always_comb begin
      lsu_st_en_o       = (state_q == ACCESS) && req_q.we && !dec_err;
      lsu_ld_byte_o     = drive_lsu && dec_ld_byte;
      lsu_ld_halfword_o = drive_lsu && dec_ld_halfword;
      lsu_addr_o        = drive_lsu ? req_q.addr : '0;
      lsu_st_data_o     = (drive_lsu && req_q.we) ? req_q.wdata : '0;

      m0_if.gnt       = (state_q == ACCESS) && !winner_q;
      m1_if.gnt       = (state_q == ACCESS) &&  winner_q;
      m0_if.rsp_valid = (state_q == RESP) && !winner_q;
      m1_if.rsp_valid = (state_q == RESP) &&  winner_q;
      m0_if.rsp_err   = (state_q == RESP) && !winner_q && dec_err;
      m1_if.rsp_err   = (state_q == RESP) &&  winner_q && dec_err;
      m0_if.rdata     = rdata_q[0];
      m1_if.rdata     = rdata_q[1];
   end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: a byte-array lsu model with registered
// zero-extending reads, plus a fixed-priority instance for the arbitration check.
module tb_lsu_arbiter;
   import lsu_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_arbiter_if #(.ADDR_W(12)) m0_if ();
   lsu_arbiter_if #(.ADDR_W(12)) m1_if ();
   lsu_arbiter_if #(.ADDR_W(12)) f0_if ();
   lsu_arbiter_if #(.ADDR_W(12)) f1_if ();

   logic        st_en, ld_b, ld_h;
   logic [11:0] laddr;
   logic [31:0] st_data, ld_data;

   logic        fp_st_en, fp_ld_b, fp_ld_h;
   logic [11:0] fp_addr;
   logic [31:0] fp_st_data;

   lsu_arbiter #(.RR_EN(1'b1), .ADDR_W(12)) dut (
      .clk_i(clk), .rst_ni(rst_n), .m0_if(m0_if), .m1_if(m1_if),
      .lsu_st_en_o(st_en), .lsu_ld_byte_o(ld_b), .lsu_ld_halfword_o(ld_h),
      .lsu_addr_o(laddr), .lsu_st_data_o(st_data), .lsu_ld_data_i(ld_data)
   );

   lsu_arbiter #(.RR_EN(1'b0), .ADDR_W(12)) dut_fp (
      .clk_i(clk), .rst_ni(rst_n), .m0_if(f0_if), .m1_if(f1_if),
      .lsu_st_en_o(fp_st_en), .lsu_ld_byte_o(fp_ld_b), .lsu_ld_halfword_o(fp_ld_h),
      .lsu_addr_o(fp_addr), .lsu_st_data_o(fp_st_data), .lsu_ld_data_i(32'h0)
   );

   // lsu model: sized little-endian stores, one-cycle registered zero-extended reads.
   logic [7:0] mem [0:4095];

   always @(posedge clk) begin
      if (st_en) begin
         mem[laddr] <= st_data[7:0];
         if (!ld_b) mem[12'(laddr + 12'd1)] <= st_data[15:8];
         if (!ld_b && !ld_h) begin
            mem[12'(laddr + 12'd2)] <= st_data[23:16];
            mem[12'(laddr + 12'd3)] <= st_data[31:24];
         end
      end
      if (ld_b)      ld_data <= {24'h0, mem[laddr]};
      else if (ld_h) ld_data <= {16'h0, mem[12'(laddr + 12'd1)], mem[laddr]};
      else           ld_data <= {mem[12'(laddr + 12'd3)], mem[12'(laddr + 12'd2)],
                                 mem[12'(laddr + 12'd1)], mem[laddr]};
   end

   function automatic logic [31:0] mem_word(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input int m, input logic r, input logic we, input logic [2:0] f3,
                        input logic [11:0] a, input logic [31:0] wd);
      if (m == 0) begin
         m0_if.req = r; m0_if.we = we; m0_if.funct3 = f3; m0_if.addr = a; m0_if.wdata = wd;
      end else begin
         m1_if.req = r; m1_if.we = we; m1_if.funct3 = f3; m1_if.addr = a; m1_if.wdata = wd;
      end
   endtask

   function automatic logic gnt_of(input int m);
      return (m == 0) ? m0_if.gnt : m1_if.gnt;
   endfunction
   function automatic logic rsp_of(input int m);
      return (m == 0) ? m0_if.rsp_valid : m1_if.rsp_valid;
   endfunction
   function automatic logic err_of(input int m);
      return (m == 0) ? m0_if.rsp_err : m1_if.rsp_err;
   endfunction
   function automatic logic [31:0] rdata_of(input int m);
      return (m == 0) ? m0_if.rdata : m1_if.rdata;
   endfunction

   // One transaction from an idle arbiter; latencies counted in cycles after the sampling edge.
   task automatic run(input string tag, input int m, input logic we, input logic [2:0] f3,
                      input logic [11:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      int gnt_lat, rsp_lat, st_cnt;
      logic err;
      logic [31:0] rd;
      gnt_lat = 0; rsp_lat = 0; st_cnt = 0; err = 1'b0; rd = '0;
      @(posedge clk); #1;
      drive(m, 1'b1, we, f3, a, wd);
      for (int k = 1; k <= 10 && rsp_lat == 0; k++) begin
         @(posedge clk); #1;
         if (gnt_of(m) && gnt_lat == 0) gnt_lat = k;
         if (st_en) st_cnt++;
         if (rsp_of(m)) begin
            rsp_lat = k;
            err = err_of(m);
            rd = rdata_of(m);
            drive(m, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
         end
      end
      if (rsp_lat == 0) drive(m, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      check({tag, "_gnt_lat"}, gnt_lat, 1);
      check({tag, "_rsp_lat"}, rsp_lat, (we || exp_err) ? 2 : 3);
      check({tag, "_st_en"}, st_cnt, (we && !exp_err) ? 1 : 0);
      check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
      check({tag, "_rdata"}, rd, exp_rd);
   endtask

   initial begin
      int order[$];
      int f0_cnt, f1_cnt, f1_seen, rsp_cnt, st_cnt, first_gnt;
      logic m0_done, m1_done;
      logic [31:0] m0_rd, m1_rd;

      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      ld_data = '0;
      drive(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      f0_if.req = 1'b0; f0_if.we = 1'b1; f0_if.funct3 = F3_W; f0_if.addr = 12'h100; f0_if.wdata = 32'h0;
      f1_if.req = 1'b0; f1_if.we = 1'b1; f1_if.funct3 = F3_W; f1_if.addr = 12'h104; f1_if.wdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt0", {31'h0, m0_if.gnt}, 32'h0);
      check("rst_rsp1", {31'h0, m1_if.rsp_valid}, 32'h0);
      check("rst_st_en", {31'h0, st_en}, 32'h0);
      check("rst_addr", {20'h0, laddr}, 32'h0);
      check("rst_rdata0", m0_if.rdata, 32'h0);
      rst_n = 1'b1;

      run("sw",    0, 1'b1, F3_W,   12'h010, 32'hDEADBEEF, 32'h0,        1'b0);
      run("lw",    0, 1'b0, F3_W,   12'h010, 32'h0,        32'hDEADBEEF, 1'b0);
      run("sb",    0, 1'b1, F3_B,   12'h020, 32'h00000085, 32'h0,        1'b0);
      run("lb",    0, 1'b0, F3_B,   12'h020, 32'h0,        32'hFFFFFF85, 1'b0);
      run("lbu",   0, 1'b0, F3_BU,  12'h020, 32'h0,        32'h00000085, 1'b0);
      run("sh",    0, 1'b1, F3_H,   12'h022, 32'h00008001, 32'h0,        1'b0);
      run("lh",    0, 1'b0, F3_H,   12'h022, 32'h0,        32'hFFFF8001, 1'b0);
      run("lhu_m1",1, 1'b0, F3_HU,  12'h022, 32'h0,        32'h00008001, 1'b0);
      run("lw_mis",0, 1'b0, F3_W,   12'h013, 32'h0,        32'h0,        1'b1);
      run("lh_mis",0, 1'b0, F3_H,   12'h011, 32'h0,        32'h0,        1'b1);
      run("f3_011",0, 1'b0, 3'b011, 12'h010, 32'h0,        32'h0,        1'b1);
      run("sw_mis",0, 1'b1, F3_W,   12'h012, 32'h12345678, 32'h0,        1'b1);
      run("sbu",   0, 1'b1, F3_BU,  12'h020, 32'h000000AA, 32'h0,        1'b1);
      check("mem_010_kept", mem_word(12'h010), 32'hDEADBEEF);
      check("mem_020_kept", mem_word(12'h020), 32'h80010085);
      run("sw_io", 1, 1'b1, F3_W,   12'h400, 32'h0000007F, 32'h0,        1'b0);
      check("io_hex0", mem_word(12'h400), 32'h0000007F);
      run("lw_io", 1, 1'b0, F3_W,   12'h400, 32'h0,        32'h0000007F, 1'b0);

      // Round robin with both requests held; m1 was served last.
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, F3_W, 12'h030, 32'h11111111);
      drive(1, 1'b1, 1'b1, F3_W, 12'h034, 32'h22222222);
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         if (m0_if.gnt) order.push_back(0);
         if (m1_if.gnt) order.push_back(1);
      end
      drive(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      check("rr_count", order.size(), 5);
      for (int i = 0; i < 4 && i < order.size(); i++)
         check($sformatf("rr_gnt%0d", i), order[i], i % 2);
      check("rr_mem_m0", mem_word(12'h030), 32'h11111111);
      check("rr_mem_m1", mem_word(12'h034), 32'h22222222);

      // Fixed priority: m1 starves while m0 holds, then is served.
      f0_cnt = 0; f1_cnt = 0; f1_seen = 0;
      f0_if.req = 1'b1; f1_if.req = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (f0_if.gnt) f0_cnt++;
         if (f1_if.gnt) f1_cnt++;
      end
      f0_if.req = 1'b0;
      for (int k = 1; k <= 5 && f1_seen == 0; k++) begin
         @(posedge clk); #1;
         if (f1_if.gnt) f1_seen = k;
      end
      f1_if.req = 1'b0;
      check("fp_m0_gnts", f0_cnt, 4);
      check("fp_m1_gnts", f1_cnt, 0);
      check("fp_m1_after", f1_seen, 1);

      // Reset during the ACCESS cycle of a store.
      repeat (3) @(posedge clk);
      #1;
      drive(0, 1'b1, 1'b1, F3_W, 12'h040, 32'hCAFEF00D);
      @(posedge clk); #1;
      check("abort_st_en_before", {31'h0, st_en}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_st_en_now", {31'h0, st_en}, 32'h0);
      drive(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      rsp_cnt = 0; st_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (m0_if.rsp_valid || m1_if.rsp_valid) rsp_cnt++;
         if (st_en) st_cnt++;
      end
      check("abort_no_rsp", rsp_cnt, 0);
      check("abort_no_st", st_cnt, 0);
      check("abort_mem", mem_word(12'h040), 32'h0);
      rst_n = 1'b1;

      // First tie after reset goes to m0.
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, F3_W, 12'h010, 32'h0);
      drive(1, 1'b1, 1'b0, F3_W, 12'h400, 32'h0);
      first_gnt = -1; m0_done = 1'b0; m1_done = 1'b0; m0_rd = '0; m1_rd = '0;
      for (int k = 1; k <= 12 && !(m0_done && m1_done); k++) begin
         @(posedge clk); #1;
         if (first_gnt < 0 && m0_if.gnt) first_gnt = 0;
         if (first_gnt < 0 && m1_if.gnt) first_gnt = 1;
         if (m0_if.rsp_valid) begin
            m0_done = 1'b1; m0_rd = m0_if.rdata;
            drive(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
         end
         if (m1_if.rsp_valid) begin
            m1_done = 1'b1; m1_rd = m1_if.rdata;
            drive(1, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
         end
      end
      drive(0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
      check("post_rst_first", first_gnt, 0);
      check("post_rst_m0_rd", m0_rd, 32'hDEADBEEF);
      check("post_rst_m1_rd", m1_rd, 32'h0000007F);
      check("post_rst_done", {30'h0, m0_done, m1_done}, 32'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the lsu data-memory/IO block.
- Shares the single lsu port between the core load/store path (m0) and the debug/program-loader port (m1).
- Sequences each access over the lsu's one-cycle registered read.
- Decodes RISC-V funct3 sizes into st_en/ld_byte/ld_halfword, rejects misaligned accesses and sign-extends LB/LH results, since the lsu only zero-extends.

Parameters:
RR_EN, 1, 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins
ADDR_W, 12, lsu byte-address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m0_req_i / m1_req_i  in  1  request level; hold with all fields stable until rsp_valid
m0_we_i / m1_we_i  in  1  1 = store, 0 = load
m0_funct3_i / m1_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
m0_addr_i / m1_addr_i  in  ADDR_W  byte address
m0_wdata_i / m1_wdata_i  in  32  store data, right-aligned
m0_gnt_o / m1_gnt_o  out  1  one-cycle pulse: request accepted
m0_rsp_valid_o / m1_rsp_valid_o  out  1  one-cycle pulse: access complete
m0_rsp_err_o / m1_rsp_err_o  out  1  valid with rsp_valid: misaligned or illegal funct3
m0_rdata_o / m1_rdata_o  out  32  load result, extended per funct3; 0 on store or err
lsu_st_en_o  out  1  to lsu st_en
lsu_ld_byte_o  out  1  to lsu ld_byte
lsu_ld_halfword_o  out  1  to lsu ld_halfword
lsu_addr_o  out  ADDR_W  to lsu addr
lsu_st_data_o  out  32  to lsu st_data
lsu_ld_data_i  in  32  from lsu ld_data

Behaviour:
Reset (asynchronous, immediate):
- FSM to IDLE; every output 0; last-grant pointer = m1, so m0 wins first.
- Reset mid-access aborts it: no st_en pulse, no rsp_valid.

FSM states: IDLE, ACCESS, READ, RESP.

IDLE:
- If any req is high, select the winner.
  - RR_EN=1: the requester not granted last wins a tie; a lone requester always wins.
  - RR_EN=0: m0 wins.
- Latch the winner's we/funct3/addr/wdata and the winner id. Pulse that requester's gnt next cycle. Go to ACCESS.
- No req: stay in IDLE with lsu_st_en_o=0.

Error check (during latch):
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Illegal funct3: 011, 110, 111, or stores with funct3[2]=1.
- An error goes to RESP with err=1. The lsu is never driven (st_en stays 0).

ACCESS:
- Drive lsu_addr_o/lsu_st_data_o from the latch.
- ld_byte = (funct3[1:0]==00); ld_halfword = (funct3[1:0]==01).
- Store: lsu_st_en_o=1 for exactly this cycle, then RESP.
- Load: go to READ.

READ:
- Hold the address.
- At the end of the cycle, capture lsu_ld_data_i into rdata:
  - B: sign-extend bit 7.
  - H: sign-extend bit 15.
  - BU/HU/W: pass through.
- Go to RESP.

RESP:
- Winner's rsp_valid=1 for one cycle, with err and rdata. Update the last-grant pointer. Go to IDLE.

Latency and throughput:
- Store: gnt at T+1, st_en at T+1, rsp at T+2 (T = cycle req first sampled in IDLE).
- Load: rsp at T+3. Error: rsp at T+2.
- Back-to-back: a req held high after rsp_valid is a new transaction. Minimum 3 cycles per store, 4 per load.

Other rules:
- The non-winning req is ignored until IDLE and must remain held.
- rdata holds its value between responses; it is cleared on store or err.
- IO addresses (0x400+) and switch addresses (0x500+) are treated like memory. No special timing.

Decomposition:
- Package lsu_arb_pkg holds:
  - state_e enum {IDLE, ACCESS, READ, RESP};
  - funct3 constants F3_B/H/W/BU/HU;
  - request struct (we, funct3, addr, wdata).
- Sub-module lsu_req_decode (combinational): funct3+addr -> ld_byte, ld_halfword, err. It also performs the load-data extension function.

Test Plan:
- m0 SW addr 0x010 wdata 0xDEADBEEF, then LW 0x010 -> st_en high exactly 1 cycle at T+1; load rsp at T+3 with rdata 0xDEADBEEF, err 0.
- SB 0x020 data 0x85, then LB 0x020 -> rdata 0xFFFFFF85; LBU -> 0x00000085. SH 0x8001 @0x022, LH -> 0xFFFF8001.
- m0 and m1 req held together continuously, RR_EN=1 -> grants m0, m1, m0, m1; with RR_EN=0 -> m0 only while held; m1 served once m0 drops.
- LW addr 0x013, LH addr 0x011, funct3 011 -> rsp_err=1, rdata 0, rsp at T+2, lsu_st_en_o never asserted, memory unchanged.
- SW to 0x400 value 0x7F -> lsu io_hex0 = 0x7F; LW 0x400 -> rdata 0x7F.
- rst_ni low during ACCESS of a store -> lsu_st_en_o drops immediately, no rsp_valid; after release the first request completes normally, m0 winning a tie.
